sig_dump: RTL and testbench
===========================

Name: sig_dump

Overview:
- Downstream consumer of the minisoc data bus and RAM for arch-test runs.
- Snoops core stores to the begin/end signature pointers (0xFFF0/0xFFF4).
- Once a valid end pointer is written, reads the signature region from RAM word by word and streams it out on a valid/ready interface with an index.
- Replaces polling of RAM from the bench; the bench or a UART bridge compares the stream against golden data.

Parameters:
- RAM_AW, 22, RAM byte-address width; mem_addr is a word address of width RAM_AW-2.
- BEGIN_PTR, 32'h0000_FFF0, byte address of the begin-signature pointer store.
- END_PTR, 32'h0000_FFF4, byte address of the end-signature pointer store.
- MAX_WORDS, 1024, maximum signature length in words (golden memory depth).

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- dbus_wr  in  1  core data-bus write strobe (one write per cycle max)
- dbus_addr  in  32  data-bus byte address
- dbus_wdata  in  32  data-bus write data
- mem_rd  out  1  RAM read request
- mem_addr  out  RAM_AW-2  RAM word address
- mem_rdata  in  32  RAM read data, valid exactly 1 cycle after mem_rd
- sig_valid  out  1  signature word valid
- sig_ready  in  1  consumer accepts word
- sig_data  out  32  signature word
- sig_idx  out  16  word index from 0
- sig_last  out  1  high with the final word
- busy  out  1  dump in progress
- done  out  1  sticky: all words transferred
- err  out  1  sticky: illegal pointer pair

Behaviour:
- Reset (asynchronous, rst_b low): all outputs 0, FSM = IDLE, begin/end registers cleared, begin_vld = 0.
- Capture:
  - Full-word write to BEGIN_PTR in IDLE latches begin and sets begin_vld.
  - A rewrite of BEGIN_PTR before END_PTR overwrites begin.
  - Bits [1:0] of both pointers are ignored (word aligned).
- Trigger: write to END_PTR in IDLE with begin_vld = 1. The same cycle evaluates:
  - Illegal if end <= begin, or begin <= 16, or (end-begin)/4 > MAX_WORDS. Then go to ERR.
  - Otherwise latch end and go to RD.
  - END_PTR written with begin_vld = 0 is ignored.
- While FSM is not IDLE, pointer writes are ignored.
- FSM:
  - IDLE
  - RD: mem_rd = 1 and mem_addr = cur[RAM_AW-1:2] for 1 cycle, then go to CAP.
  - CAP: register mem_rdata into sig_data, set sig_valid, then go to OUT.
  - OUT: hold sig_valid/data/idx/last stable until sig_ready. On handshake, cur += 4 and idx++. Go to DONE if this was the last word, else RD.
  - DONE: terminal.
  - ERR: terminal.
- Timing:
  - Throughput is one word per 3 cycles when sig_ready = 1.
  - First sig_valid rises 2 cycles after the END_PTR write cycle.
- Signals:
  - sig_last = (cur + 4 == end) while sig_valid.
  - busy = 1 in RD/CAP/OUT.
  - done = 1 in DONE, err = 1 in ERR. Both stay set until reset.
- Arithmetic: pointers are 32-bit unsigned; word count = (end-begin)>>2; sig_idx wraps at 16 bits (unreachable given MAX_WORDS).
- sig_ready while sig_valid = 0 is ignored. sig_valid never drops without a handshake.
- Reset mid-stream aborts immediately; no partial state survives.

Optional Feature:
- Macro: SIG_DUMP_CHECKSUM_EN.
- Defined:
  - Adds output sig_checksum [31:0], reset 0.
  - On each handshake: sig_checksum = {sig_checksum[30:0], sig_checksum[31]} ^ sig_data (rotate-left-1 then XOR).
  - Value is final when done rises.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package sig_dump_pkg:
  - state enum sig_state_e {IDLE, RD, CAP, OUT, DONE, ERR}
  - BEGIN_PTR/END_PTR default constants
  - checksum step function
- Sub-module sig_dump_ptr_cap: pointer capture, legality check and begin_vld, so the streaming FSM stays separate.

Test Plan:
- Basic: RAM[0x2000..0x200C] = 11,22,33,44; write 0xFFF0 = 0x2000, then 0xFFF4 = 0x2010; sig_ready = 1 → 4 words 0x11..0x44, idx 0..3, sig_last only on idx 3, done = 1, busy = 0, first valid 2 cycles after the END write.
- Backpressure: same setup with sig_ready low for 5 cycles on idx 1 → data/idx held stable, no duplicate or skipped word, mem_rd not reasserted while in OUT.
- Errors: end = 0x2000, begin = 0x2000 → err = 1, sig_valid never set. begin = 0x10, end = 0x100 → err. Length 1025 words → err.
- Ignored writes: END written before BEGIN → ignored, FSM stays IDLE. BEGIN rewritten during streaming → no effect on the stream.
- Reset mid-stream: rst_b low while streaming idx 2 → all outputs 0 immediately. A fresh pointer pair afterwards streams again from idx 0.
- With SIG_DUMP_CHECKSUM_EN: words 1, 2 → sig_checksum = 0x00000000 after the 2nd handshake (rot(1) = 2, 2 ^ 2 = 0). Words 1, 3 → 0x00000001.

Source files
------------

// File: rtl/sig_dump_pkg.sv
// Shared types and constants for the signature dumper (sig_dump and sig_dump_ptr_cap).
// Holds the FSM state enum, pointer address defaults and the checksum step.
package sig_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } sig_state_e;

  localparam int          RAM_AW_DEF    = 22;
  localparam logic [31:0] BEGIN_PTR_DEF = 32'h0000_FFF0;
  localparam logic [31:0] END_PTR_DEF   = 32'h0000_FFF4;
  localparam int          MAX_WORDS_DEF = 1024;

  // Rotate-left-by-one, then fold in the new word.
  function automatic logic [31:0] chk_step(input logic [31:0] acc, input logic [31:0] data);
    return {acc[30:0], acc[31]} ^ data;
  endfunction

endpackage

// File: rtl/sig_dump_ptr_cap.sv
// Snoops data-bus stores to the begin/end signature pointers and judges the pair.
// Pulses start_o for a legal pair and bad_o for an illegal one, only while idle_i.
module sig_dump_ptr_cap
  import sig_dump_pkg::*;
#(
  parameter logic [31:0] BEGIN_PTR = BEGIN_PTR_DEF,
  parameter logic [31:0] END_PTR   = END_PTR_DEF,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        idle_i,
  output logic [31:0] begin_o,
  output logic [31:0] end_o,
  output logic        start_o,
  output logic        bad_o
);

  logic [31:0] begin_q, begin_d;
  logic [31:0] end_q, end_d;
  logic        begin_vld_q, begin_vld_d;
  logic [31:0] wptr, span_words;
  logic        wr_begin, wr_end, illegal;

  // Pointers are word aligned; the low two bits of the store data carry no meaning.
  assign wptr       = wdata_i & ~32'h3;
  assign span_words = (wptr - begin_q) >> 2;
  assign wr_begin   = idle_i && wr_i && (addr_i == BEGIN_PTR);
  assign wr_end     = idle_i && wr_i && (addr_i == END_PTR) && begin_vld_q;
  assign illegal    = (wptr <= begin_q) || (begin_q <= 32'd16) ||
                      (span_words > 32'(MAX_WORDS));

  assign start_o = wr_end && !illegal;
  assign bad_o   = wr_end && illegal;
  assign begin_o = begin_q;
  assign end_o   = end_q;

  always_comb begin
    begin_d     = begin_q;
    begin_vld_d = begin_vld_q;
    end_d       = end_q;
    if (wr_begin) begin
      begin_d     = wptr;
      begin_vld_d = 1'b1;
    end
    if (start_o) end_d = wptr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      begin_q     <= '0;
      end_q       <= '0;
      begin_vld_q <= 1'b0;
    end else begin
      begin_q     <= begin_d;
      end_q       <= end_d;
      begin_vld_q <= begin_vld_d;
    end
  end

endmodule

// File: rtl/sig_dump.sv
// Signature dumper: once a legal begin/end pointer pair is stored, streams RAM words
// out on a valid/ready port. Define SIG_DUMP_CHECKSUM_EN to add the sig_checksum output.
module sig_dump
  import sig_dump_pkg::*;
#(
  parameter int          RAM_AW    = RAM_AW_DEF,
  parameter logic [31:0] BEGIN_PTR = BEGIN_PTR_DEF,
  parameter logic [31:0] END_PTR   = END_PTR_DEF,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              dbus_wr,
  input  logic [31:0]       dbus_addr,
  input  logic [31:0]       dbus_wdata,
  output logic              mem_rd,
  output logic [RAM_AW-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [31:0]       sig_data,
  output logic [15:0]       sig_idx,
  output logic              sig_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SIG_DUMP_CHECKSUM_EN
  ,
  output logic [31:0]       sig_checksum
`endif
);

  sig_state_e  state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [31:0] begin_w, end_w;
  logic        start, bad, hs, last;

  sig_dump_ptr_cap #(
    .BEGIN_PTR (BEGIN_PTR),
    .END_PTR   (END_PTR),
    .MAX_WORDS (MAX_WORDS)
  ) u_ptr_cap (
    .clk_i   (clk),
    .rst_ni  (rst_b),
    .wr_i    (dbus_wr),
    .addr_i  (dbus_addr),
    .wdata_i (dbus_wdata),
    .idle_i  (state_q == IDLE),
    .begin_o (begin_w),
    .end_o   (end_w),
    .start_o (start),
    .bad_o   (bad)
  );

  assign hs       = (state_q == OUT) && sig_ready;
  assign last     = (cur_q + 32'd4) == end_w;
  assign sig_data = data_q;
  assign sig_idx  = idx_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD;
               else if (bad) state_d = ERR;
      RD:      state_d = CAP;
      CAP:     state_d = OUT;
      OUT:     if (sig_ready) state_d = last ? DONE : RD;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = '0;
    sig_valid = 1'b0;
    sig_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = cur_q[RAM_AW-1:2];
        busy     = 1'b1;
      end
      CAP:  busy = 1'b1;
      OUT: begin
        sig_valid = 1'b1;
        sig_last  = last;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  // Word pointer, index and output word; the pointer advances only on a handshake.
  always_comb begin
    cur_d  = cur_q;
    idx_d  = idx_q;
    data_d = data_q;
    if (start) begin
      cur_d = begin_w;
      idx_d = '0;
    end
    if (state_q == CAP) data_d = mem_rdata;
    if (hs) begin
      cur_d = cur_q + 32'd4;
      idx_d = idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cur_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      cur_q  <= cur_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

`ifdef SIG_DUMP_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  assign chk_d        = hs ? chk_step(chk_q, data_q) : chk_q;
  assign sig_checksum = chk_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) chk_q <= '0;
    else        chk_q <= chk_d;
  end
`endif

endmodule

// File: tb/tb_sig_dump.sv
// Self-checking bench for sig_dump: RAM model, scoreboard of expected stream words,
// error/ignore/reset scenarios and, with SIG_DUMP_CHECKSUM_EN, checksum values.
`timescale 1ns/1ps
module tb_sig_dump;

  localparam int          RAM_AW = 22;
  localparam logic [31:0] BPTR   = 32'h0000_FFF0;
  localparam logic [31:0] EPTR   = 32'h0000_FFF4;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              dbus_wr = 1'b0;
  logic [31:0]       dbus_addr = '0;
  logic [31:0]       dbus_wdata = '0;
  logic              mem_rd;
  logic [RAM_AW-3:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              sig_valid;
  logic              sig_ready = 1'b0;
  logic [31:0]       sig_data;
  logic [15:0]       sig_idx;
  logic              sig_last, busy, done, err;
`ifdef SIG_DUMP_CHECKSUM_EN
  logic [31:0]       sig_checksum;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ram [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_words  = 0;
  bit          stalled;

  sig_dump #(.RAM_AW(RAM_AW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .dbus_wr    (dbus_wr),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .sig_data   (sig_data),
    .sig_idx    (sig_idx),
    .sig_last   (sig_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef SIG_DUMP_CHECKSUM_EN
    ,
    .sig_checksum (sig_checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: data is valid the cycle after the read request, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? ram[mem_addr[11:0]] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_b && sig_valid) begin
      check("rd_in_out", 32'(mem_rd), 32'd0);
      if (sig_ready) begin
        check("sb_depth", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("data", sig_data, mon_e.data);
          check("idx", 32'(sig_idx), 32'(mon_e.idx));
          check("last", 32'(sig_last), 32'(mon_e.last));
          n_words++;
        end
      end
    end
    if (rst_b && mem_rd) check("addr_range", 32'(mem_addr[RAM_AW-3:12]), 32'd0);
  end

  task automatic check_zero();
    check("z_mem_rd", 32'(mem_rd), 32'd0);
    check("z_mem_addr", 32'(mem_addr), 32'd0);
    check("z_valid", 32'(sig_valid), 32'd0);
    check("z_data", sig_data, 32'd0);
    check("z_idx", 32'(sig_idx), 32'd0);
    check("z_last", 32'(sig_last), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    check("z_done", 32'(done), 32'd0);
    check("z_err", 32'(err), 32'd0);
`ifdef SIG_DUMP_CHECKSUM_EN
    check("z_chk", sig_checksum, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    sb.delete();
    #1;
    check_zero();
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    n_words = 0;
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    dbus_wr = 1'b1; dbus_addr = a; dbus_wdata = d;
    @(posedge clk); #1;
    dbus_wr = 1'b0; dbus_addr = '0; dbus_wdata = '0;
  endtask

  task automatic push_stream(input logic [31:0] b, input logic [31:0] e);
    logic [15:0] i = '0;
    for (logic [31:0] a = b; a < e; a += 32'd4) begin
      sb.push_back('{data: ram[a[13:2]], idx: i, last: (a + 32'd4 == e)});
      i++;
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] eb [4] = '{32'h2000, 32'h10,  32'h2000, 32'h2010};
  logic [31:0] ee [4] = '{32'h2000, 32'h100, 32'h3004, 32'h2000};

  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    ram[12'h800] = 32'h11; ram[12'h801] = 32'h22;
    ram[12'h802] = 32'h33; ram[12'h803] = 32'h44;
    do_reset();

    // Basic stream with latency checks on the first word.
    sig_ready = 1'b1;
    push_stream(32'h2000, 32'h2010);
    bus_wr(BPTR, 32'h2000);
    bus_wr(EPTR, 32'h2010);
    @(negedge clk);
    check("rd_cycle_rd", 32'(mem_rd), 32'd1);
    check("rd_cycle_addr", 32'(mem_addr), 32'h800);
    check("rd_cycle_valid", 32'(sig_valid), 32'd0);
    check("rd_cycle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("cap_valid", 32'(sig_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(sig_valid), 32'd1);
    @(posedge clk); #1;
    wait_done(100);
    check("basic_words", 32'(n_words), 32'd4);
    check("basic_err", 32'(err), 32'd0);

    // Backpressure: hold idx 1 for five cycles.
    do_reset();
    sig_ready = 1'b1;
    stalled = 1'b0;
    push_stream(32'h2000, 32'h2010);
    bus_wr(BPTR, 32'h2000);
    bus_wr(EPTR, 32'h2010);
    for (int c = 0; c < 80 && !done; c++) begin
      @(posedge clk); #1;
      if (sig_valid && sig_idx == 16'd1 && !stalled) begin
        sig_ready = 1'b0;
        stalled = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(sig_valid), 32'd1);
          check("stall_data", sig_data, 32'h22);
          check("stall_idx", 32'(sig_idx), 32'd1);
          @(posedge clk); #1;
        end
        sig_ready = 1'b1;
      end
    end
    check("stall_seen", 32'(stalled), 32'd1);
    wait_done(20);
    check("bp_words", 32'(n_words), 32'd4);

    // Illegal pointer pairs.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      bus_wr(BPTR, eb[k]);
      bus_wr(EPTR, ee[k]);
      @(negedge clk);
      check("bad_err", 32'(err), 32'd1);
      check("bad_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      check("bad_valid", 32'(sig_valid), 32'd0);
      check("bad_err_sticky", 32'(err), 32'd1);
      @(posedge clk); #1;
    end

    // Legal boundaries: one word just above begin=16, and exactly MAX_WORDS.
    do_reset();
    push_stream(32'h14, 32'h18);
    bus_wr(BPTR, 32'h14);
    bus_wr(EPTR, 32'h18);
    wait_done(30);
    check("one_words", 32'(n_words), 32'd1);
    do_reset();
    push_stream(32'h2000, 32'h3000);
    bus_wr(BPTR, 32'h2001);
    bus_wr(EPTR, 32'h3003);
    wait_done(3200);
    check("max_words", 32'(n_words), 32'd1024);
    check("max_err", 32'(err), 32'd0);

    // Ignored writes: END before BEGIN, BEGIN rewrite, pointer writes mid-stream.
    do_reset();
    bus_wr(EPTR, 32'h2010);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    bus_wr(BPTR, 32'h3000);
    bus_wr(BPTR, 32'h2000);
    push_stream(32'h2000, 32'h2010);
    bus_wr(EPTR, 32'h2010);
    repeat (4) @(posedge clk);
    #1;
    bus_wr(BPTR, 32'h3000);
    bus_wr(EPTR, 32'h3010);
    wait_done(100);
    check("ign_words", 32'(n_words), 32'd4);

    // Reset while idx 2 is presented, then a fresh dump.
    do_reset();
    push_stream(32'h2000, 32'h2010);
    bus_wr(BPTR, 32'h2000);
    bus_wr(EPTR, 32'h2010);
    for (int c = 0; c < 50 && !(sig_valid && sig_idx == 16'd2); c++) begin
      @(posedge clk); #1;
    end
    check("mid_at_idx2", 32'(sig_valid && sig_idx == 16'd2), 32'd1);
    check("mid_words", 32'(n_words), 32'd2);
    rst_b = 1'b0;
    sb.delete();
    #1;
    check_zero();
    @(negedge clk);
    rst_b = 1'b1;
    n_words = 0;
    @(posedge clk); #1;
    push_stream(32'h3000, 32'h3008);
    bus_wr(BPTR, 32'h3000);
    bus_wr(EPTR, 32'h3008);
    wait_done(50);
    check("fresh_words", 32'(n_words), 32'd2);

`ifdef SIG_DUMP_CHECKSUM_EN
    do_reset();
    ram[12'hC00] = 32'd1; ram[12'hC01] = 32'd2;
    push_stream(32'h3000, 32'h3008);
    bus_wr(BPTR, 32'h3000);
    bus_wr(EPTR, 32'h3008);
    wait_done(50);
    check("chk_1_2", sig_checksum, 32'h0000_0000);
    do_reset();
    ram[12'hC01] = 32'd3;
    push_stream(32'h3000, 32'h3008);
    bus_wr(BPTR, 32'h3000);
    bus_wr(EPTR, 32'h3008);
    wait_done(50);
    check("chk_1_3", sig_checksum, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
